exp3_unidade_controle: RTL and testbench
========================================

EXP3_UNIDADE_CONTROLE -- requirements
Module: exp3_unidade_controle

Interface
REQ-001 Parameter TIMEOUT, default 5000, SHALL set the number of clock cycles allowed in ESPERA before timeout; legal range 2..65535.
REQ-002 clock  input  1  SHALL be the single system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset: 0 forces the reset state immediately, independent of clock.
REQ-004 iniciar  input  1  SHALL be the level start request.
REQ-005 jogada  input  1  SHALL be the level key-press indication, high while any switch is pressed.
REQ-006 chavesIgualMemoria  input  1  SHALL be the datapath comparator equality result.
REQ-007 fimC  input  1  SHALL be the datapath address-counter ripple carry, high at address 15.
REQ-008 zeraC, contaC, zeraR, registraR  output  1 each  SHALL be the datapath counter clear, counter enable, register clear and register load.
REQ-009 pronto  output  1  SHALL flag that the round has ended, for any reason.
REQ-010 acertou, errou, timeout  output  1 each  SHALL flag the round outcome.
REQ-011 db_estado  output  4  SHALL expose the current state code.

Function
REQ-012 The FSM SHALL be Moore with registered state; all outputs SHALL be decoded from state only.
REQ-013 State codes SHALL be: INICIAL 0x0, PREPARACAO 0x1, ESPERA 0x2, REGISTRA 0x4, COMPARA 0x5, PROXIMO 0x6, FIM_ACERTO 0xA, FIM_TIMEOUT 0xD, FIM_ERRO 0xE; unused codes SHALL return to INICIAL on the next edge.
REQ-014 INICIAL: all outputs 0; iniciar=1 SHALL cause a transition to PREPARACAO, otherwise hold.
REQ-015 PREPARACAO: zeraC=1 and zeraR=1 for exactly one cycle, then unconditionally ESPERA.
REQ-016 ESPERA: jogada rising edge (jogada=1 this cycle, 0 previous sampled cycle) SHALL go to REGISTRA; all datapath controls 0.
REQ-017 A jogada already high on entry to ESPERA SHALL NOT count as a jogada edge; it SHALL be released and pressed again.
REQ-018 A 16-bit timeout counter SHALL clear on every entry to ESPERA and increment each cycle spent in ESPERA.
REQ-019 When the counter equals TIMEOUT-1 with no jogada edge that cycle, the FSM SHALL go to FIM_TIMEOUT.
REQ-020 A jogada edge in the same cycle as the counter reaching TIMEOUT-1 SHALL take priority: go to REGISTRA.
REQ-021 REGISTRA: registraR=1 for exactly one cycle, then COMPARA.
REQ-022 COMPARA: all controls 0; transitions by priority: chavesIgualMemoria=0 -> FIM_ERRO; else fimC=1 -> FIM_ACERTO; else -> PROXIMO.
REQ-023 PROXIMO: contaC=1 for exactly one cycle, then ESPERA; the synchronous ROM thus has at least 2 cycles to settle before the next COMPARA.
REQ-024 Final states SHALL assert pronto=1 plus exactly one of acertou/errou/timeout, hold every datapath control at 0, and hold the state until iniciar=1 -> PREPARACAO.
REQ-025 iniciar SHALL be ignored in every state except INICIAL and the final states.
REQ-026 Latency: from a valid jogada edge to a final state or back to ESPERA SHALL be 3 cycles (REGISTRA, COMPARA, PROXIMO or final).
REQ-027 The jogada edge register SHALL sample jogada every cycle in every state.

Reset
REQ-028 While reset=0: state = INICIAL; timeout counter = 0; jogada edge register = 0; all outputs 0; db_estado = 0x0.
REQ-029 Reset asserted mid-round SHALL abort immediately; datapath clears occur only via the next PREPARACAO.

Verification
REQ-030 Reset, iniciar=1 for 1 cycle -> db_estado 0x0 -> 0x1 (zeraC=zeraR=1 for one cycle) -> 0x2.
REQ-031 16 jogada pulses with chavesIgualMemoria=1, fimC=1 only at the 16th COMPARA -> 16 registraR pulses, 15 contaC pulses, FIM_ACERTO (pronto=1, acertou=1, db_estado 0xA).
REQ-032 3rd jogada with chavesIgualMemoria=0 -> FIM_ERRO (errou=1, db_estado 0xE); contaC pulse count = 2.
REQ-033 TIMEOUT=8, no jogada -> FIM_TIMEOUT exactly 8 cycles after entering ESPERA; with TIMEOUT=8 and a jogada edge in the 8th cycle -> REGISTRA.
REQ-034 jogada held high through PREPARACAO -> FSM stays in ESPERA until jogada falls and rises again; reset=0 asserted during COMPARA -> outputs 0 and db_estado 0x0 without waiting for a clock edge.

Source files
------------

// File: rtl/exp3_unidade_controle_if.sv
// Control-unit bundle between the game FSM and its datapath/environment.
//   iniciar, jogada             : level requests from the player side
//   chavesIgualMemoria, fimC    : datapath status (comparator equal, counter at 15)
//   zeraC, contaC, zeraR,
//   registraR                   : datapath controls
//   pronto, acertou, errou,
//   timeout                     : round outcome flags
//   db_estado                   : current state code for debug
// Modport slave is the control unit; master is whoever drives it.
interface exp3_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, jogada, chavesIgualMemoria, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport master (
    output iniciar, jogada, chavesIgualMemoria, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp3_unidade_controle.sv
// Moore control unit for one round of the memory game: clears the datapath,
// waits for a key press (with timeout), registers and compares the keys, and
// advances the address until a hit, a miss or a timeout ends the round.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : control/status bundle (slave side), see exp3_unidade_controle_if
//   TIMEOUT : cycles allowed in ESPERA before the round times out (2..65535)
module exp3_unidade_controle #(
  parameter int unsigned TIMEOUT = 5000
) (
  input logic                    clock,
  input logic                    reset,
  exp3_unidade_controle_if.slave bus
);

  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPreparacao = 4'h1,
    StEspera     = 4'h2,
    StRegistra   = 4'h4,
    StCompara    = 4'h5,
    StProximo    = 4'h6,
    StFimAcerto  = 4'hA,
    StFimTimeout = 4'hD,
    StFimErro    = 4'hE
  } estado_e;

  localparam logic [15:0] LimiteCnt = 16'(TIMEOUT - 1);

  // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [7:0] decodifica(input estado_e e);
    logic [7:0] s;
    s = 8'b0;
    case (e)
      StPreparacao: s = 8'b1010_0000;
      StRegistra:   s = 8'b0001_0000;
      StProximo:    s = 8'b0100_0000;
      StFimAcerto:  s = 8'b0000_1100;
      StFimErro:    s = 8'b0000_1010;
      StFimTimeout: s = 8'b0000_1001;
      default:      s = 8'b0;
    endcase
    return s;
  endfunction

  estado_e     estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic        jogada_q;
  logic        jogada_borda;
  logic [7:0]  saida_q;

  // A press already held when ESPERA is entered has jogada_q=1 and is ignored.
  assign jogada_borda = bus.jogada & ~jogada_q;

  always_comb begin
    estado_d = estado_q;
    // Zero outside ESPERA, so every entry into ESPERA starts counting from 0.
    cnt_d    = (estado_q == StEspera) ? cnt_q + 16'd1 : 16'd0;
    case (estado_q)
      StInicial:    if (bus.iniciar) estado_d = StPreparacao;
      StPreparacao: estado_d = StEspera;
      StEspera: begin
        // A press in the last allowed cycle still wins over the timeout.
        if (jogada_borda)            estado_d = StRegistra;
        else if (cnt_q == LimiteCnt) estado_d = StFimTimeout;
      end
      StRegistra:   estado_d = StCompara;
      StCompara: begin
        if (!bus.chavesIgualMemoria) estado_d = StFimErro;
        else if (bus.fimC)           estado_d = StFimAcerto;
        else                         estado_d = StProximo;
      end
      StProximo:    estado_d = StEspera;
      StFimAcerto, StFimTimeout, StFimErro: begin
        if (bus.iniciar) estado_d = StPreparacao;
      end
      default:      estado_d = StInicial;
    endcase
  end

  // Outputs are registered from the next state so they always equal the
  // decode of the current state, without a combinational path to the pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
      cnt_q    <= 16'd0;
      jogada_q <= 1'b0;
      saida_q  <= 8'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      jogada_q <= bus.jogada;
      saida_q  <= decodifica(estado_d);
    end
  end

  assign bus.zeraC     = saida_q[7];
  assign bus.contaC    = saida_q[6];
  assign bus.zeraR     = saida_q[5];
  assign bus.registraR = saida_q[4];
  assign bus.pronto    = saida_q[3];
  assign bus.acertou   = saida_q[2];
  assign bus.errou     = saida_q[1];
  assign bus.timeout   = saida_q[0];
  assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Directed bench for exp3_unidade_controle with TIMEOUT=8. Each step pushes
// the expected state/outputs to a scoreboard before the clock edge and pops
// and compares after it.
module tb_exp3_unidade_controle;

  logic clock;
  logic reset;

  exp3_unidade_controle_if dut_if ();

  exp3_unidade_controle #(
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dut_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_reg = 0;
  int n_conta = 0;

  logic [11:0] sb_q[$];
  logic [11:0] obs;

  assign obs = {dut_if.db_estado, dut_if.zeraC, dut_if.contaC, dut_if.zeraR, dut_if.registraR,
                dut_if.pronto, dut_if.acertou, dut_if.errou, dut_if.timeout};

  always @(negedge clock) begin
    if (reset) begin
      if (dut_if.registraR) n_reg++;
      if (dut_if.contaC) n_conta++;
    end
  end

  // Expected outputs for a state code, straight from the state/output table.
  function automatic logic [11:0] exp_vec(input logic [3:0] s);
    logic zc, cc, zr, rr, pr, ac, er, to;
    zc = (s == 4'h1);
    zr = (s == 4'h1);
    rr = (s == 4'h4);
    cc = (s == 4'h6);
    ac = (s == 4'hA);
    to = (s == 4'hD);
    er = (s == 4'hE);
    pr = ac | to | er;
    return {s, zc, cc, zr, rr, pr, ac, er, to};
  endfunction

  task automatic check_out(input string tag);
    logic [11:0] e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick(input logic [3:0] s, input string tag);
    sb_q.push_back(exp_vec(s));
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  // One key press from ESPERA through COMPARA to the decision state.
  task automatic rodada(input logic igual, input logic fim, input logic [3:0] final_s);
    dut_if.jogada = 1'b1;
    tick(4'h4, "registra");
    dut_if.jogada = 1'b0;
    dut_if.chavesIgualMemoria = igual;
    dut_if.fimC = fim;
    tick(4'h5, "compara");
    tick(final_s, "decisao");
    if (final_s == 4'h6) tick(4'h2, "volta_espera");
    dut_if.fimC = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0;
    reset = 1'b0;
    dut_if.iniciar = 1'b0;
    dut_if.jogada = 1'b0;
    dut_if.chavesIgualMemoria = 1'b1;
    dut_if.fimC = 1'b0;

    #2;
    sb_q.push_back(exp_vec(4'h0));
    check_out("reset_inicial");
    @(posedge clock);
    #1;
    reset = 1'b1;

    tick(4'h0, "inicial_hold");
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera");

    // Full round of 16 hits.
    r0 = n_reg;
    c0 = n_conta;
    for (int i = 0; i < 16; i++) rodada(1'b1, (i == 15), (i == 15) ? 4'hA : 4'h6);
    check_int("registraR_pulsos_16", n_reg - r0, 16);
    check_int("contaC_pulsos_15", n_conta - c0, 15);
    dut_if.jogada = 1'b1;
    tick(4'hA, "acerto_hold");
    dut_if.jogada = 1'b0;
    tick(4'hA, "acerto_hold2");

    // Miss on the 3rd press; fimC high does not mask the miss.
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao2");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera2");
    c0 = n_conta;
    rodada(1'b1, 1'b0, 4'h6);
    rodada(1'b1, 1'b0, 4'h6);
    rodada(1'b0, 1'b1, 4'hE);
    check_int("contaC_pulsos_2", n_conta - c0, 2);
    tick(4'hE, "erro_hold");

    // Timeout: FIM_TIMEOUT exactly 8 edges after entering ESPERA.
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao3");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera3");
    for (int i = 0; i < 7; i++) tick(4'h2, "espera_conta");
    tick(4'hD, "fim_timeout");
    tick(4'hD, "timeout_hold");

    // Press in the 8th ESPERA cycle wins over the timeout.
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao4");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera4");
    for (int i = 0; i < 7; i++) tick(4'h2, "espera_conta2");
    rodada(1'b1, 1'b0, 4'h6);
    // Counter restarts on re-entry: full 8 cycles again.
    for (int i = 0; i < 7; i++) tick(4'h2, "espera_conta3");
    tick(4'hD, "fim_timeout2");

    // jogada held high through PREPARACAO is not a press; iniciar ignored in ESPERA.
    dut_if.jogada = 1'b1;
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao5");
    tick(4'h2, "espera_segurada");
    tick(4'h2, "espera_segurada2");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera_segurada3");
    dut_if.jogada = 1'b0;
    tick(4'h2, "espera_solta");
    dut_if.jogada = 1'b1;
    tick(4'h4, "registra_nova");
    dut_if.jogada = 1'b0;
    dut_if.chavesIgualMemoria = 1'b1;
    tick(4'h5, "compara_antes_reset");

    // Asynchronous reset in COMPARA, checked before any further clock edge.
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(exp_vec(4'h0));
    check_out("reset_async");
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(4'h0, "pos_reset");
    dut_if.iniciar = 1'b1;
    tick(4'h1, "preparacao6");
    dut_if.iniciar = 1'b0;
    tick(4'h2, "espera6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
